mem_stage: RTL

Memory stage of the five-stage MIPS pipeline, directly downstream of the ALU. It captures the ALU results (alu_out, write_data, write_reg_addr, zero, pc_branch) and EX control bits in an EX/MEM register, and resolves beq/bne. It performs word loads and stores on an internal synchronous data memory and delivers write-back data through a MEM/WB register. It also exports EX/MEM forwarding information to the hazard/forwarding unit.

---
 rtl/mem_stage_if.sv | 45 ++++
 rtl/mem_stage.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// EX->MEM->WB bundle for mem_stage: EX-side inputs, pipeline control, forwarding and write-back results.
// Master drives EX/control and observes results; the stage itself is the slave.
interface mem_stage_if;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_write_data;
    logic [4:0]  ex_write_reg_addr;
    logic        ex_zero;
    logic [31:0] ex_pc_branch;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        ex_mem_to_reg;
    logic        ex_branch_eq;
    logic        ex_branch_ne;

    logic        branch_taken;
    logic [31:0] branch_target;
    logic        fwd_reg_write;
    logic [4:0]  fwd_reg_addr;
    logic [31:0] fwd_data;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_reg_addr;
    logic [31:0] wb_data;
    logic        misalign_err;

    modport master (
        output stall, flush, ex_valid, ex_alu_out, ex_write_data, ex_write_reg_addr,
               ex_zero, ex_pc_branch, ex_mem_read, ex_mem_write, ex_reg_write,
               ex_mem_to_reg, ex_branch_eq, ex_branch_ne,
        input  branch_taken, branch_target, fwd_reg_write, fwd_reg_addr, fwd_data,
               wb_valid, wb_reg_write, wb_reg_addr, wb_data, misalign_err
    );

    modport slave (
        input  stall, flush, ex_valid, ex_alu_out, ex_write_data, ex_write_reg_addr,
               ex_zero, ex_pc_branch, ex_mem_read, ex_mem_write, ex_reg_write,
               ex_mem_to_reg, ex_branch_eq, ex_branch_ne,
        output branch_taken, branch_target, fwd_reg_write, fwd_reg_addr, fwd_data,
               wb_valid, wb_reg_write, wb_reg_addr, wb_data, misalign_err
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, branch resolve, word data memory, MEM/WB register; EX->WB in 2 edges.
// Backpressure: stall holds EX/MEM and bubbles MEM/WB; flush bubbles EX/MEM while its old content advances.
module mem_stage #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic         clk,
    input  logic         rst,
    mem_stage_if.slave   bus
);

    typedef struct packed {
        logic        valid;
        logic [31:0] alu_out;
        logic [31:0] write_data;
        logic [4:0]  reg_addr;
        logic        zero;
        logic [31:0] pc_branch;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic        branch_eq;
        logic        branch_ne;
    } exmem_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [4:0]  reg_addr;
        logic        mem_to_reg;
        logic        load_ok;
        logic [31:0] alu_out;
    } memwb_t;

    exmem_t em_q;
    exmem_t em_d;
    memwb_t mw_q;
    memwb_t mw_d;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       rd_q;
    logic              misalign_q;

    logic              advance;
    logic              aligned;
    logic              mem_access;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] idx;

    // A flush always lets the current MEM occupant move on, even under stall.
    assign advance    = ~bus.stall | bus.flush;
    assign aligned    = (em_q.alu_out[1:0] == 2'b00);
    assign idx        = em_q.alu_out[ADDR_W+1:2];
    assign mem_access = em_q.valid & (em_q.mem_read | em_q.mem_write);
    assign wr_en      = advance & em_q.valid & em_q.mem_write & aligned;
    assign rd_en      = advance & em_q.valid & em_q.mem_read & aligned;

    always_comb begin
        em_d            = '0;
        em_d.valid      = bus.ex_valid;
        em_d.alu_out    = bus.ex_alu_out;
        em_d.write_data = bus.ex_write_data;
        em_d.reg_addr   = bus.ex_write_reg_addr;
        em_d.zero       = bus.ex_zero;
        em_d.pc_branch  = bus.ex_pc_branch;
        em_d.mem_read   = bus.ex_mem_read;
        em_d.mem_write  = bus.ex_mem_write;
        em_d.reg_write  = bus.ex_reg_write;
        em_d.mem_to_reg = bus.ex_mem_to_reg;
        em_d.branch_eq  = bus.ex_branch_eq;
        em_d.branch_ne  = bus.ex_branch_ne;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            em_q <= '0;
        end else if (bus.flush) begin
            em_q <= '0;
        end else if (!bus.stall) begin
            em_q <= em_d;
        end
    end

    always_comb begin
        mw_d = '0;
        if (advance) begin
            mw_d.valid      = em_q.valid;
            mw_d.reg_write  = em_q.valid & em_q.reg_write;
            mw_d.reg_addr   = em_q.reg_addr;
            mw_d.mem_to_reg = em_q.mem_to_reg;
            mw_d.load_ok    = em_q.mem_read & aligned;
            mw_d.alu_out    = em_q.alu_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mw_q <= '0;
        end else begin
            mw_q <= mw_d;
        end
    end

    // Array contents are deliberately left unreset; rst clears EX/MEM first so no write escapes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= em_q.write_data;
        end
        if (rd_en) begin
            rd_q <= mem[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (advance && mem_access && !aligned) begin
            misalign_q <= 1'b1;
        end
    end

    assign bus.branch_taken  = em_q.valid & ~bus.stall &
                               ((em_q.branch_eq & em_q.zero) | (em_q.branch_ne & ~em_q.zero));
    assign bus.branch_target = em_q.pc_branch;
    assign bus.fwd_reg_write = em_q.valid & em_q.reg_write & ~em_q.mem_read;
    assign bus.fwd_reg_addr  = em_q.reg_addr;
    assign bus.fwd_data      = em_q.alu_out;

    assign bus.wb_valid      = mw_q.valid;
    assign bus.wb_reg_write  = mw_q.reg_write;
    assign bus.wb_reg_addr   = mw_q.reg_addr;
    // Misaligned loads return zero; rd_q is not reset, so it is never exposed unless a load filled it.
    assign bus.wb_data       = mw_q.mem_to_reg ? (mw_q.load_ok ? rd_q : 32'h0) : mw_q.alu_out;
    assign bus.misalign_err  = misalign_q;

endmodule
